// File: rtl/nbits_up_counter_pkg.sv
// Shared constants and load-source encoding
// for the push-button up-counter.
package counter_pkg;

    localparam int N_DEFAULT = 6;
    localparam int DISP_W    = 6;

    localparam int BTN_INC  = 0;
    localparam int BTN_NUM1 = 1;
    localparam int BTN_NUM2 = 2;
    localparam int BTN_NUM3 = 3;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_NUM1,
        SRC_NUM2,
        SRC_NUM3,
        SRC_INC
    } src_e;

endpackage

// File: rtl/nbits_up_counter_if.sv
// Button inputs and counter/display outputs
// grouped for the up-counter.
interface nbits_up_counter_if #(
    parameter int n = 6
);

    logic         inc;
    logic         num1;
    logic         num2;
    logic         num3;
    logic [n-1:0] count;
    logic         ovf;
    logic [6:0]   segA;
    logic [6:0]   segB;

    modport master (
        output inc, num1, num2, num3,
        input  count, ovf, segA, segB
    );

    modport slave (
        input  inc, num1, num2, num3,
        output count, ovf, segA, segB
    );

endinterface

// File: rtl/bcd_6bits.sv
// 6-bit binary to two-digit decimal
// 7-segment decoder (active-high, gfedcba).
module bcd_6bits (
    input  logic [5:0] bits,
    output logic [6:0] segA,
    output logic [6:0] segB
);

    logic [5:0] tens;
    logic [5:0] units;

    function automatic logic [6:0] seg7(
        input logic [3:0] d
    );
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign tens  = bits / 6'd10;
    assign units = bits % 6'd10;

    assign segA = seg7(tens[3:0]);
    assign segB = seg7(units[3:0]);

endmodule

// File: rtl/nbits_up_counter_adder.sv
// Ripple-carry adder built from a chain
// of full adders; purely combinational.
module n_bits_adder #(
    parameter int n = 6
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] s,
    output logic         cout
);

    logic [n:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < n; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i])
                      | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[n];

endmodule

// File: rtl/nbits_up_counter.sv
// Button-driven up-counter with preset loads,
// wrap overflow pulse and decimal display.
module nbits_up_counter
    import counter_pkg::*;
#(
    parameter int n = N_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    nbits_up_counter_if.slave bus
);

    localparam logic [n-1:0] MID =
        {1'b1, {(n-1){1'b0}}};
    localparam logic [n-1:0] TOP_M1 =
        {{(n-1){1'b1}}, 1'b0};
    localparam logic [n-1:0] ONE =
        {{(n-1){1'b0}}, 1'b1};

    logic [3:0]      btn;
    logic [3:0]      pulse;
    src_e            src;
    logic [n-1:0]    count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [n-1:0]    sum;
    logic            cout;
    logic [DISP_W-1:0] disp;

    assign btn[BTN_INC]  = bus.inc;
    assign btn[BTN_NUM1] = bus.num1;
    assign btn[BTN_NUM2] = bus.num2;
    assign btn[BTN_NUM3] = bus.num3;

    // Two-flop synchroniser plus previous-level
    // flop gives one pulse per rising press.
    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic s1_q, s2_q, p_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
                p_q  <= 1'b0;
            end else begin
                s1_q <= btn[i];
                s2_q <= s1_q;
                p_q  <= s2_q;
            end
        end

        assign pulse[i] = s2_q & ~p_q;
    end

    always_comb begin
        src = SRC_NONE;
        priority case (1'b1)
            pulse[BTN_NUM1]: src = SRC_NUM1;
            pulse[BTN_NUM2]: src = SRC_NUM2;
            pulse[BTN_NUM3]: src = SRC_NUM3;
            pulse[BTN_INC]:  src = SRC_INC;
            default:         src = SRC_NONE;
        endcase
    end

    n_bits_adder #(.n(n)) u_add (
        .a    (count_q),
        .b    (ONE),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        case (src)
            SRC_NUM1: count_d = '0;
            SRC_NUM2: count_d = MID;
            SRC_NUM3: count_d = TOP_M1;
            SRC_INC: begin
                count_d = sum;
                ovf_d   = cout;
            end
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;
    assign disp      = DISP_W'(count_q);

    bcd_6bits u_bcd (
        .bits (disp),
        .segA (bus.segA),
        .segB (bus.segB)
    );

endmodule

// File: tb/tb_nbits_up_counter.sv
// Directed bench for nbits_up_counter (n=6):
// latency, wrap, priority, reset behaviour.
module tb_nbits_up_counter;

    localparam logic [6:0] S0 = 7'h3F;
    localparam logic [6:0] S2 = 7'h5B;
    localparam logic [6:0] S3 = 7'h4F;
    localparam logic [6:0] S6 = 7'h7D;

    localparam logic [3:0] M_INC  = 4'b0001;
    localparam logic [3:0] M_NUM1 = 4'b0010;
    localparam logic [3:0] M_NUM2 = 4'b0100;
    localparam logic [3:0] M_NUM3 = 4'b1000;

    logic clk;
    logic reset;
    int   nvec;
    int   nerr;
    logic [5:0] cur;

    nbits_up_counter_if #(.n(6)) bus ();

    nbits_up_counter #(.n(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic setb(input logic [3:0] m);
        bus.inc  = m[0];
        bus.num1 = m[1];
        bus.num2 = m[2];
        bus.num3 = m[3];
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Press at negedge before E0; count moves at E2.
    task automatic press(
        input string      tag,
        input logic [3:0] m,
        input logic [5:0] exp,
        input logic       exp_ovf
    );
        @(negedge clk);
        setb(m);
        cyc(2);
        chk({tag, ".pre"}, 32'(bus.count), 32'(cur));
        cyc(1);
        chk({tag, ".upd"}, 32'(bus.count), 32'(exp));
        chk({tag, ".ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        cur = exp;
        cyc(2);
        chk({tag, ".held"}, 32'(bus.count), 32'(cur));
        chk({tag, ".ovf0"}, 32'(bus.ovf), 32'd0);
        @(negedge clk);
        setb(4'b0000);
        cyc(4);
        chk({tag, ".rel"}, 32'(bus.count), 32'(cur));
    endtask

    initial begin
        nvec  = 0;
        nerr  = 0;
        cur   = 6'd0;
        reset = 1'b1;
        setb(4'b0000);

        cyc(3);
        chk("rst.count", 32'(bus.count), 32'd0);
        chk("rst.ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc(10);
        chk("idle.count", 32'(bus.count), 32'd0);
        chk("idle.ovf", 32'(bus.ovf), 32'd0);
        chk("idle.segA", 32'(bus.segA), 32'(S0));
        chk("idle.segB", 32'(bus.segB), 32'(S0));

        for (int i = 1; i <= 5; i++)
            press("inc5", M_INC, 6'(i), 1'b0);
        chk("inc5.count", 32'(bus.count), 32'd5);

        press("num3", M_NUM3, 6'd62, 1'b0);
        chk("62.segA", 32'(bus.segA), 32'(S6));
        chk("62.segB", 32'(bus.segB), 32'(S2));
        press("inc63", M_INC, 6'd63, 1'b0);
        chk("63.segA", 32'(bus.segA), 32'(S6));
        chk("63.segB", 32'(bus.segB), 32'(S3));
        press("wrap", M_INC, 6'd0, 1'b1);
        chk("0.segA", 32'(bus.segA), 32'(S0));
        chk("0.segB", 32'(bus.segB), 32'(S0));

        press("inc1", M_INC, 6'd1, 1'b0);
        press("n1n2i", M_NUM1 | M_NUM2 | M_INC,
              6'd0, 1'b0);
        press("n2i", M_NUM2 | M_INC, 6'd32, 1'b0);
        press("n1", M_NUM1, 6'd0, 1'b0);

        reset = 1'b1;
        setb(M_NUM2);
        cyc(2);
        chk("rhold.rst", 32'(bus.count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc(2);
        chk("rhold.pre", 32'(bus.count), 32'd0);
        cyc(1);
        chk("rhold.upd", 32'(bus.count), 32'd32);
        chk("rhold.ovf", 32'(bus.ovf), 32'd0);
        cyc(6);
        chk("rhold.held", 32'(bus.count), 32'd32);
        @(negedge clk);
        setb(4'b0000);
        cyc(4);
        cur = 6'd32;

        for (int i = 33; i <= 40; i++)
            press("to40", M_INC, 6'(i), 1'b0);
        chk("c40", 32'(bus.count), 32'd40);

        @(negedge clk);
        setb(M_INC);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst.count", 32'(bus.count), 32'd0);
        chk("midrst.ovf", 32'(bus.ovf), 32'd0);
        setb(4'b0000);
        @(negedge clk);
        reset = 1'b0;
        cyc(6);
        chk("midrst.after", 32'(bus.count), 32'd0);
        chk("midrst.segB", 32'(bus.segB), 32'(S0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
